// File: rtl/score_round_ctrl.sv
// End-of-round score controller: snapshots the BCD score, keeps the best score,
// runs the new-record blink celebration and requests a score-counter flush.
module score_round_ctrl #(
    parameter int BLINK_TICKS      = 12_500_000,
    parameter int CELEBRATE_BLINKS = 8,
    parameter int FLUSH_CYCLES     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       round_end,
    input  logic       clear_best,
    input  logic [3:0] score_low,
    input  logic [3:0] score_high,
    output logic [3:0] best_low,
    output logic [3:0] best_high,
    output logic       new_record,
    output logic       record_blink,
    output logic       reset_flags,
    output logic       round_busy
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_COMPARE   = 2'd1;
    localparam logic [1:0] ST_CELEBRATE = 2'd2;
    localparam logic [1:0] ST_FLUSH     = 2'd3;

    localparam int TOGGLES = 2 * CELEBRATE_BLINKS;
    localparam int BW      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int TW      = $clog2(TOGGLES);
    localparam int FW      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_TICKS - 1);
    localparam logic [TW-1:0] TOGGLE_LAST = TW'(TOGGLES - 1);
    localparam logic [FW-1:0] FLUSH_LAST  = FW'(FLUSH_CYCLES - 1);

    logic [1:0]    state;
    logic [3:0]    snap_low;
    logic [3:0]    snap_high;
    logic [BW-1:0] blink_cnt;
    logic [TW-1:0] toggle_cnt;
    logic [FW-1:0] flush_cnt;

    // Out-of-range BCD digits are clamped to 9 so the 8-bit compare stays meaningful.
    function automatic logic [3:0] sat_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            snap_low     <= 4'd0;
            snap_high    <= 4'd0;
            best_low     <= 4'd0;
            best_high    <= 4'd0;
            new_record   <= 1'b0;
            record_blink <= 1'b0;
            blink_cnt    <= '0;
            toggle_cnt   <= '0;
            flush_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (round_end) begin
                        snap_high  <= sat_bcd(score_high);
                        snap_low   <= sat_bcd(score_low);
                        new_record <= 1'b0;
                        state      <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    // A simultaneous clear_best discards the compare result.
                    if (!clear_best && ({snap_high, snap_low} > {best_high, best_low})) begin
                        best_high    <= snap_high;
                        best_low     <= snap_low;
                        new_record   <= 1'b1;
                        record_blink <= 1'b1;
                        blink_cnt    <= '0;
                        toggle_cnt   <= '0;
                        state        <= ST_CELEBRATE;
                    end else begin
                        flush_cnt <= '0;
                        state     <= ST_FLUSH;
                    end
                end
                ST_CELEBRATE: begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        if (toggle_cnt == TOGGLE_LAST) begin
                            record_blink <= 1'b0;
                            flush_cnt    <= '0;
                            state        <= ST_FLUSH;
                        end else begin
                            record_blink <= ~record_blink;
                            toggle_cnt   <= toggle_cnt + 1'b1;
                        end
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                default: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
            endcase

            if (clear_best) begin
                best_high <= 4'd0;
                best_low  <= 4'd0;
            end
        end
    end

    assign reset_flags = (state == ST_FLUSH);
    assign round_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_score_round_ctrl.sv
// Directed bench for score_round_ctrl with short blink/flush timing.
module tb_score_round_ctrl;

    logic       clk;
    logic       reset;
    logic       round_end;
    logic       clear_best;
    logic [3:0] score_low;
    logic [3:0] score_high;
    logic [3:0] best_low;
    logic [3:0] best_high;
    logic       new_record;
    logic       record_blink;
    logic       reset_flags;
    logic       round_busy;

    int vectors;
    int miscompares;

    score_round_ctrl #(
        .BLINK_TICKS(4),
        .CELEBRATE_BLINKS(2),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .round_end(round_end),
        .clear_best(clear_best),
        .score_low(score_low),
        .score_high(score_high),
        .best_low(best_low),
        .best_high(best_high),
        .new_record(new_record),
        .record_blink(record_blink),
        .reset_flags(reset_flags),
        .round_busy(round_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies one round_end pulse (optionally with clear_best) and stops just after E1.
    task automatic do_round(input logic [3:0] h, input logic [3:0] l, input logic cb_e0,
                            input logic cb_e1);
        score_high = h;
        score_low  = l;
        round_end  = 1'b1;
        clear_best = cb_e0;
        tick();
        round_end  = 1'b0;
        clear_best = cb_e1;
        check("busy_compare", {7'd0, round_busy}, 8'h01);
        tick();
        clear_best = 1'b0;
    endtask

    // Expected shape of a full celebration, following E1; optionally pokes round_end.
    task automatic run_celebration(input string name, input logic [7:0] best_exp, input logic poke);
        for (int k = 1; k <= 18; k++) begin
            if (poke && (k == 6 || k == 17)) begin
                score_high = 4'h9;
                score_low  = 4'h9;
                round_end  = 1'b1;
            end
            tick();
            round_end = 1'b0;
            if (k < 16) begin
                check({name, "_blink"}, {7'd0, record_blink}, {7'd0, ((k / 4) % 2) == 0});
                check({name, "_rf_lo"}, {7'd0, reset_flags}, 8'h00);
            end else if (k < 18) begin
                check({name, "_blink_end"}, {7'd0, record_blink}, 8'h00);
                check({name, "_rf_hi"}, {7'd0, reset_flags}, 8'h01);
            end else begin
                check({name, "_rf_done"}, {7'd0, reset_flags}, 8'h00);
                check({name, "_idle"}, {7'd0, round_busy}, 8'h00);
            end
        end
        check({name, "_best_hold"}, {best_high, best_low}, best_exp);
        check({name, "_nr_hold"}, {7'd0, new_record}, 8'h01);
    endtask

    // No-record round: flush starts right after E1 and lasts two cycles.
    task automatic expect_flush(input string name, input logic [7:0] best_exp);
        check({name, "_best"}, {best_high, best_low}, best_exp);
        check({name, "_nr"}, {7'd0, new_record}, 8'h00);
        check({name, "_blink"}, {7'd0, record_blink}, 8'h00);
        check({name, "_rf0"}, {7'd0, reset_flags}, 8'h01);
        tick();
        check({name, "_rf1"}, {7'd0, reset_flags}, 8'h01);
        tick();
        check({name, "_rf2"}, {7'd0, reset_flags}, 8'h00);
        check({name, "_idle"}, {7'd0, round_busy}, 8'h00);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        round_end   = 1'b0;
        clear_best  = 1'b0;
        score_low   = 4'h0;
        score_high  = 4'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset from mid-celebration
        do_round(4'h5, 4'h5, 1'b0, 1'b0);
        check("pre_best", {best_high, best_low}, 8'h55);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_best", {best_high, best_low}, 8'h00);
        check("rst_nr", {7'd0, new_record}, 8'h00);
        check("rst_blink", {7'd0, record_blink}, 8'h00);
        check("rst_rf", {7'd0, reset_flags}, 8'h00);
        check("rst_busy", {7'd0, round_busy}, 8'h00);
        tick();
        check("rst_idle_next", {7'd0, round_busy}, 8'h00);

        // Score 00 is never a record
        do_round(4'h0, 4'h0, 1'b0, 1'b0);
        expect_flush("zero", 8'h00);

        // Record 37 with round_end pokes during celebration and flush
        do_round(4'h3, 4'h7, 1'b0, 1'b0);
        check("r37_best", {best_high, best_low}, 8'h37);
        check("r37_nr", {7'd0, new_record}, 8'h01);
        check("r37_blink", {7'd0, record_blink}, 8'h01);
        check("r37_rf", {7'd0, reset_flags}, 8'h00);
        run_celebration("r37", 8'h37, 1'b1);

        // Lower and equal scores
        do_round(4'h2, 4'h9, 1'b0, 1'b0);
        expect_flush("r29", 8'h37);
        do_round(4'h3, 4'h7, 1'b0, 1'b0);
        expect_flush("r37eq", 8'h37);

        // Reset mid-celebration never issues a flush
        do_round(4'h4, 4'h2, 1'b0, 1'b0);
        check("r42_best", {best_high, best_low}, 8'h42);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r42_rst_best", {best_high, best_low}, 8'h00);
        check("r42_rst_blink", {7'd0, record_blink}, 8'h00);
        for (int k = 0; k < 20; k++) begin
            check("r42_no_flush", {7'd0, reset_flags}, 8'h00);
            tick();
        end

        // Saturated high digit: A5 -> 95
        do_round(4'h3, 4'h7, 1'b0, 1'b0);
        run_celebration("r37b", 8'h37, 1'b0);
        do_round(4'hA, 4'h5, 1'b0, 1'b0);
        check("rA5_best", {best_high, best_low}, 8'h95);
        check("rA5_nr", {7'd0, new_record}, 8'h01);
        run_celebration("rA5", 8'h95, 1'b0);

        // clear_best together with round_end in IDLE
        score_high = 4'h1;
        score_low  = 4'h2;
        round_end  = 1'b1;
        clear_best = 1'b1;
        tick();
        round_end  = 1'b0;
        clear_best = 1'b0;
        check("r12_clr_e0", {best_high, best_low}, 8'h00);
        tick();
        check("r12_best", {best_high, best_low}, 8'h12);
        check("r12_nr", {7'd0, new_record}, 8'h01);
        run_celebration("r12", 8'h12, 1'b0);

        // clear_best at the COMPARE edge discards the record
        do_round(4'h5, 4'h0, 1'b0, 1'b1);
        expect_flush("r50_clr", 8'h00);

        // Saturated low digit: 1C -> 19
        do_round(4'h1, 4'hC, 1'b0, 1'b0);
        check("r1C_best", {best_high, best_low}, 8'h19);
        run_celebration("r1C", 8'h19, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
